// File: rtl/seq_divider_if.sv
// seq_divider_if: operator/display bundle for the sequential divider (master = operator side, slave = divider)
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Din;
    logic             Load_Divisor;
    logic             Execute;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [5:0]       debug;

    modport master (
        output Din, Load_Divisor, Execute,
        input  Quotient, Remainder, Divisor, Busy, Done, DivZero, debug
    );

    modport slave (
        input  Din, Load_Divisor, Execute,
        output Quotient, Remainder, Divisor, Busy, Done, DivZero, debug
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract unsigned divider; SEQ_DIVIDER_FAST_EN merges shift and subtract into one state per bit
module seq_divider #(
    parameter int WIDTH = 8
) (
    input logic         Clk,
    input logic         Reset_n,
    seq_divider_if.slave bus
);
    localparam logic [5:0] ST_START  = 6'd0;
`ifdef SEQ_DIVIDER_FAST_EN
    localparam logic [5:0] ST_FINISH = 6'(WIDTH + 1);
`else
    localparam logic [5:0] ST_FINISH = 6'(2 * WIDTH + 1);
`endif

    logic [5:0]       state;
    logic [WIDTH:0]   r, tr_base, diff;
    logic [WIDTH-1:0] q, q_base, d;
    logic             dz, shift_phase;

    // Trial-subtract operands: pre-shifted in fast mode, raw registers in the two-cycle mode
    always_comb begin
`ifdef SEQ_DIVIDER_FAST_EN
        tr_base     = {r[WIDTH-1:0], q[WIDTH-1]};
        q_base      = {q[WIDTH-2:0], 1'b0};
        shift_phase = 1'b0;
`else
        tr_base     = r;
        q_base      = q;
        shift_phase = state[0];
`endif
        diff = tr_base - {1'b0, d};
    end

    // Control FSM and datapath; iteration states simply count up into Finish
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_START;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            dz    <= 1'b0;
        end else if (state == ST_START) begin
            if (bus.Load_Divisor) begin
                d <= bus.Din;
            end else if (bus.Execute) begin
                if (d != '0) begin
                    q     <= bus.Din;
                    r     <= '0;
                    dz    <= 1'b0;
                    state <= 6'd1;
                end else begin
                    q     <= '1;
                    r     <= {1'b0, bus.Din};
                    dz    <= 1'b1;
                    state <= ST_FINISH;
                end
            end
        end else if (state == ST_FINISH) begin
            if (!bus.Execute) state <= ST_START;
        end else begin
            if (shift_phase) begin
                {r, q} <= {r[WIDTH-1:0], q, 1'b0};
            end else begin
                r <= diff[WIDTH] ? tr_base : diff;
                q <= {q_base[WIDTH-1:1], ~diff[WIDTH]};
            end
            state <= state + 6'd1;
        end
    end

    assign bus.Quotient  = q;
    assign bus.Remainder = r[WIDTH-1:0];
    assign bus.Divisor   = d;
    assign bus.DivZero   = dz;
    assign bus.Busy      = (state != ST_START) && (state != ST_FINISH);
    assign bus.Done      = (state == ST_FINISH);
    assign bus.debug     = state;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider against an arithmetic division model
module tb_seq_divider;
    localparam int W = 8;
`ifdef SEQ_DIVIDER_FAST_EN
    localparam int LAT      = W + 1;
    localparam int BUSY_CYC = W;
    localparam int ST_SH3   = 4;
    localparam int ST_SB4   = 5;
`else
    localparam int LAT      = 2 * W + 1;
    localparam int BUSY_CYC = 2 * W;
    localparam int ST_SH3   = 7;
    localparam int ST_SB4   = 10;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int checks = 0;
    int fails = 0;
    logic [W-1:0] model_d = '0;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic load_divisor(input logic [W-1:0] dv);
        @(negedge Clk);
        bus.Din = dv;
        bus.Load_Divisor = 1'b1;
        @(negedge Clk);
        bus.Load_Divisor = 1'b0;
        model_d = dv;
        checks++;
        if (bus.Divisor !== dv) begin
            fails++;
            $display("FAIL load_divisor: Divisor=%0d expected %0d", bus.Divisor, dv);
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] a, input int drop_state);
        logic [W-1:0] eq, er;
        logic edz;
        int elat, ebusy, cyc, bc;
        if (model_d == 0) begin
            eq = '1; er = a; edz = 1'b1; elat = 1; ebusy = 0;
        end else begin
            eq = a / model_d; er = a % model_d; edz = 1'b0; elat = LAT; ebusy = BUSY_CYC;
        end
        @(negedge Clk);
        bus.Din = a;
        bus.Execute = 1'b1;
        cyc = 0;
        bc = 0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (bus.Busy === 1'b1) bc++;
            if (bus.Done === 1'b1 || cyc >= 200) break;
            if (drop_state >= 0 && bus.debug == 6'(drop_state)) bus.Execute = 1'b0;
            bus.Din = W'($urandom);
            bus.Load_Divisor = 1'($urandom);
        end
        bus.Load_Divisor = 1'b0;
        checks++;
        if (cyc !== elat) begin fails++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, elat); end
        checks++;
        if (bus.Quotient !== eq) begin fails++; $display("FAIL %s quotient: got %0d expected %0d", name, bus.Quotient, eq); end
        checks++;
        if (bus.Remainder !== er) begin fails++; $display("FAIL %s remainder: got %0d expected %0d", name, bus.Remainder, er); end
        checks++;
        if (bus.DivZero !== edz) begin fails++; $display("FAIL %s divzero: got %0b expected %0b", name, bus.DivZero, edz); end
        checks++;
        if (bus.Divisor !== model_d) begin fails++; $display("FAIL %s divisor_kept: got %0d expected %0d", name, bus.Divisor, model_d); end
        checks++;
        if (bc !== ebusy) begin fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, ebusy); end
        if (drop_state < 0) begin
            repeat (2) @(negedge Clk);
            checks++;
            if (bus.Done !== 1'b1 || bus.Quotient !== eq) begin
                fails++;
                $display("FAIL %s hold_finish: Done=%0b Q=%0d expected Done=1 Q=%0d", name, bus.Done, bus.Quotient, eq);
            end
            bus.Execute = 1'b0;
        end
        @(negedge Clk);
        checks++;
        if (bus.debug !== 6'd0 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL %s return_start: state=%0d Done=%0b expected state=0 Done=0", name, bus.debug, bus.Done);
        end
    endtask

    task automatic test_reset();
        bus.Din = '0;
        bus.Load_Divisor = 1'b0;
        bus.Execute = 1'b0;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({bus.Quotient, bus.Remainder, bus.Divisor, bus.Busy, bus.Done, bus.DivZero, bus.debug} !== '0) begin
            fails++;
            $display("FAIL reset: Q=%0d R=%0d D=%0d Busy=%0b Done=%0b DZ=%0b state=%0d expected all 0",
                     bus.Quotient, bus.Remainder, bus.Divisor, bus.Busy, bus.Done, bus.DivZero, bus.debug);
        end
        Reset_n = 1'b1;
        model_d = '0;
    endtask

    task automatic test_basic();
        load_divisor(8'd7);
        run_check("basic_100_div_7", 8'd100, -1);
    endtask

    task automatic test_boundaries();
        load_divisor(8'd1);
        run_check("255_div_1", 8'd255, -1);
        load_divisor(8'd255);
        run_check("255_div_255", 8'd255, -1);
        load_divisor(8'd9);
        run_check("5_div_9", 8'd5, -1);
    endtask

    task automatic test_divzero();
        load_divisor(8'd0);
        run_check("div_by_zero", 8'd42, -1);
        load_divisor(8'd5);
        run_check("after_divzero", 8'd77, -1);
    endtask

    task automatic test_priority();
        @(negedge Clk);
        bus.Din = 8'd3;
        bus.Load_Divisor = 1'b1;
        bus.Execute = 1'b1;
        @(negedge Clk);
        bus.Load_Divisor = 1'b0;
        bus.Execute = 1'b0;
        model_d = 8'd3;
        checks++;
        if (bus.Divisor !== 8'd3 || bus.debug !== 6'd0 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL load_priority: D=%0d state=%0d Busy=%0b expected D=3 state=0 Busy=0", bus.Divisor, bus.debug, bus.Busy);
        end
    endtask

    task automatic test_execute_drop();
        run_check("execute_drop", 8'd200, ST_SH3);
    endtask

    task automatic test_reset_midrun();
        int n;
        load_divisor(8'd6);
        @(negedge Clk);
        bus.Din = 8'd200;
        bus.Execute = 1'b1;
        n = 0;
        while (bus.debug != 6'(ST_SB4) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            fails++;
            $display("FAIL reset_midrun_reach: state=%0d expected %0d", bus.debug, ST_SB4);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.Quotient, bus.Remainder, bus.Divisor, bus.Busy, bus.Done, bus.DivZero, bus.debug} !== '0) begin
            fails++;
            $display("FAIL reset_midrun: Q=%0d R=%0d D=%0d Busy=%0b Done=%0b DZ=%0b state=%0d expected all 0",
                     bus.Quotient, bus.Remainder, bus.Divisor, bus.Busy, bus.Done, bus.DivZero, bus.debug);
        end
        model_d = '0;
        bus.Execute = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        load_divisor(8'd13);
        run_check("after_reset", 8'd250, -1);
    endtask

    task automatic test_random();
        logic [W-1:0] dv, a;
        for (int i = 0; i < 16; i++) begin
            dv = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
            a = W'($urandom);
            load_divisor(dv);
            run_check($sformatf("random_%0d", i), a, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_divzero();
        test_priority();
        test_execute_drop();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned shift-subtract (restoring) divider for the lab datapath.
- It is the inverse companion to the shift-add multiplier controller and shares its operator handshake: divisor load, Execute, then hold until Execute is released.
- It contains both the control FSM and the quotient, remainder and divisor registers, and drives the hex displays and LEDs directly.

Parameters:
- WIDTH, 8, operand width; the run takes WIDTH iterations.

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Din  in  WIDTH  switch input, used for the divisor or the dividend
- Load_Divisor  in  1  captures Din into the divisor register (Start state only)
- Execute  in  1  starts a division; level-held operator control
- Quotient  out  WIDTH  quotient register; holds the dividend during a run
- Remainder  out  WIDTH  low WIDTH bits of the remainder register
- Divisor  out  WIDTH  current divisor register value
- Busy  out  1  high in every iteration state
- Done  out  1  high in the Finish state
- DivZero  out  1  sticky flag: the last Execute saw divisor == 0
- debug  out  6  current state encoding

Behaviour:
- Reset (Reset_n low, asynchronous, takes effect at any time including mid-run):
  - state = Start
  - Quotient = 0, remainder register = 0, Divisor = 0
  - Busy = Done = DivZero = 0
- Registers:
  - Divisor D: WIDTH bits.
  - Remainder R: WIDTH+1 bits. The extra bit absorbs the shift overflow. The Remainder port is R[WIDTH-1:0].
  - Quotient/dividend Q: WIDTH bits.
  - All outputs are registered or decoded from state only. There are no combinational input-to-output paths.
- States:
  - Start, then SH0, SB0, SH1, SB1, … SH(WIDTH-1), SB(WIDTH-1), then Finish.
  - With WIDTH = 8 that is 18 states, so the state vector is 6 bits.
- Start:
  - If Load_Divisor = 1: D <= Din and stay in Start. Load_Divisor has priority over Execute in the same cycle; Execute is ignored that cycle.
  - Else if Execute = 1 and D != 0: Q <= Din, R <= 0, DivZero <= 0, go to SH0.
  - Else if Execute = 1 and D == 0: Q <= all ones, R <= {0, Din}, DivZero <= 1, go straight to Finish.
  - Otherwise hold.
- SHk: {R,Q} <= {R,Q} << 1, with 0 shifted into Q[0]. Next state is SBk.
- SBk:
  - Compute t = R − {0,D} at WIDTH+1 bits.
  - If t[WIDTH] = 0 (no borrow): R <= t and Q[0] <= 1.
  - Otherwise R is unchanged and Q[0] <= 0.
  - Next state is SH(k+1), or Finish after SB(WIDTH-1).
- Finish: outputs hold. Go to Start when Execute = 0; otherwise stay in Finish.
- Timing:
  - Latency from the Execute-sampling edge to Done high is 2·WIDTH+1 cycles (17 for WIDTH = 8).
  - A divide-by-zero result gives Done after 1 cycle.
- Inputs during a run: Execute deasserted mid-run is ignored and the run completes. Load_Divisor and Din changes outside Start are ignored.
- Result invariant when D != 0: Din_dividend = Q·D + R, with R < D.
- Busy = 1 in SHk and SBk states. Done = 1 in Finish only.
- debug = state encoding: Start = 0, then ascending in listed order, Finish = 2·WIDTH+1.

Optional Feature:
- Macro: SEQ_DIVIDER_FAST_EN.
- When defined:
  - The SH and SB states merge into one state per iteration, ITk.
  - In ITk the shifted value is formed combinationally and the trial subtract is applied to it in the same cycle.
  - Latency is WIDTH+1 cycles (9 for WIDTH = 8). Finish encoding = WIDTH+1.
- When undefined: two cycles per iteration, exactly as described in Behaviour.
- Unchanged either way: results, the DivZero path and the handshake.

Test Plan:
- Reset_n low, then high. Load_Divisor with Din = 7. Execute with Din = 100 → after 17 cycles Done = 1, Quotient = 14, Remainder = 2, DivZero = 0. Stays in Finish until Execute = 0, then Start.
- D = 1, dividend 255 → Quotient = 255, Remainder = 0. D = 255, dividend 255 → Quotient = 1, Remainder = 0.
- D = 9, dividend 5 → Quotient = 0, Remainder = 5. Busy is high for exactly 16 cycles.
- D = 0, Execute with dividend 42 → 1 cycle later Done = 1, DivZero = 1, Quotient = 0xFF, Remainder = 42. A following valid run clears DivZero.
- Load_Divisor and Execute asserted together in Start with Din = 3 → D = 3 and the FSM stays in Start. Execute dropped at SH3 mid-run → run still completes with the correct result and returns to Start one cycle after Finish.
- Reset_n pulsed low during SB4 → immediately Start with all outputs 0. The next full run gives correct results. Repeat the scenarios with SEQ_DIVIDER_FAST_EN defined and check 9-cycle latency.
